// File: rtl/data_mem_responder_pkg.sv
// Definitions shared by the processor top and its data-memory responder:
// FSM state encoding, request/response field widths and a width helper.
package data_mem_responder_pkg;

    localparam int DMEM_DATA_W   = 32;
    localparam int DMEM_ADDR_W   = 32;
    localparam int DMEM_ERRCNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    // Bits needed to index n items, never less than one.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/data_mem_responder_mem_word_ram.sv
// Word RAM behind the data-memory responder: synchronous write, combinational read.
// Indices at or beyond DEPTH_WORDS read as zero and are never written.
module mem_word_ram #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = 6
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH_WORDS);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
    logic                  wr_in_range;
    logic                  rd_in_range;

    assign wr_in_range = ({1'b0, waddr_i} < DEPTH_L);
    assign rd_in_range = ({1'b0, raddr_i} < DEPTH_L);

    always_ff @(posedge clk) begin
        if (we_i && wr_in_range) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = rd_in_range ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the processor data-memory interface: accepts one load/store,
// waits WAIT_CYCLES, then answers with a one-cycle rsp_valid pulse.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH  = DMEM_DATA_W,
    parameter int ADDR_WIDTH  = DMEM_ADDR_W,
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic                     req_write,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     req_ready,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [DMEM_ERRCNT_W-1:0] err_count
);

    localparam int                       CNT_W   = clog2_min1(WAIT_CYCLES + 1);
    localparam int                       IDX_W   = clog2_min1(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-1:0]    DEPTH_A = ADDR_WIDTH'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0]         WAIT_LD = CNT_W'(WAIT_CYCLES);
    localparam logic [DMEM_ERRCNT_W-1:0] ERR_MAX = '1;

    // Full-width range compare so a non-power-of-two depth never aliases.
    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH_A);
    endfunction

    dmem_state_e                state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       write_q, write_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic                       rsp_err_q, rsp_err_d;
    logic [DMEM_ERRCNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic                       hs;
    logic                       enter_resp;
    logic [ADDR_WIDTH-1:0]      src_addr;
    logic                       src_write;
    logic                       src_err;
    logic                       ram_we;
    logic [IDX_W-1:0]           rd_idx;
    logic [IDX_W-1:0]           wr_idx;
    logic [DATA_WIDTH-1:0]      ram_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
    end

    assign hs = req_valid && req_ready;

    // With zero wait states RESP is entered straight from IDLE, before the
    // request has been latched, so the live request is the source then.
    assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    assign src_addr   = (state_q == ST_IDLE) ? req_addr  : addr_q;
    assign src_write  = (state_q == ST_IDLE) ? req_write : write_q;
    assign src_err    = addr_err(src_addr);
    assign rd_idx     = src_addr[IDX_W+1:2];
    assign wr_idx     = addr_q[IDX_W+1:2];
    assign ram_we     = (state_q == ST_RESP) && write_q && !rsp_err_q;

    always_comb begin
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        err_cnt_d = err_cnt_q;
        if (hs) begin
            write_d = req_write;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            cnt_d   = WAIT_LD;
        end else if (state_q == ST_WAIT) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        rsp_err_d   = enter_resp && src_err;
        rsp_rdata_d = (enter_resp && !src_write && !src_err) ? ram_rdata : '0;
        if ((state_q == ST_RESP) && rsp_err_q && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + DMEM_ERRCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign err_count = err_cnt_q;

    mem_word_ram #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_idx),
        .wdata_i (wdata_q),
        .raddr_i (rd_idx),
        .rdata_o (ram_rdata)
    );

endmodule
